// File: rtl/serial_subtractor_8_bit_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_8_bit_if
// Handshake and data bundle between a controlling FSM (master) and the
// bit-serial subtractor (slave): start/a/b/bin toward the subtractor,
// busy/done/diff/bout back to the controller.
// Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow flag ovf.
// -----------------------------------------------------------------------------
interface serial_subtractor_8_bit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

`ifdef SERIAL_SUB_OVF_EN
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
`else
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
`endif

endinterface : serial_subtractor_8_bit_if

// File: rtl/serial_subtractor_8_bit.sv
// -----------------------------------------------------------------------------
// serial_subtractor_8_bit
// Bit-serial subtractor: diff = (a - b - bin) mod 2^WIDTH, one bit per clock,
// LSB first, with a single borrow flip-flop.  Handshake is start/busy/done.
//   IDLE --start--> RUN (WIDTH cycles) --> DONE (one cycle, done=1) --> IDLE
// The partial result lives in its own shift register; diff/bout (and ovf)
// are only written at the RUN->DONE edge, so the previous result stays
// visible while a new operation is running.
// Optional macro SERIAL_SUB_OVF_EN adds a signed-overflow output ovf.
// -----------------------------------------------------------------------------
module serial_subtractor_8_bit #(
    parameter int WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    serial_subtractor_8_bit_if.slave  bus
);

    // Counter wide enough to hold WIDTH-1 (WIDTH >= 2 keeps this >= 1 bit).
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // -------------------------------------------------------------------------
    // Full-subtractor bit slice helpers
    // -------------------------------------------------------------------------
    function automatic logic sub_diff_bit(input logic a0, input logic b0,
                                          input logic brw);
        return a0 ^ b0 ^ brw;
    endfunction

    function automatic logic sub_borrow_bit(input logic a0, input logic b0,
                                            input logic brw);
        return (~a0 & b0) | (~(a0 ^ b0) & brw);
    endfunction

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_e           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             brw_q,    brw_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             bout_q,   bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q,    ovf_d;
`endif

    // Current bit slice outputs (operand LSBs against the running borrow).
    logic             step_diff_s;
    logic             step_brw_s;
    logic [WIDTH-1:0] res_next_s;

    assign step_diff_s = sub_diff_bit(a_sh_q[0], b_sh_q[0], brw_q);
    assign step_brw_s  = sub_borrow_bit(a_sh_q[0], b_sh_q[0], brw_q);
    assign res_next_s  = {step_diff_s, res_sh_q[WIDTH-1:1]};

    // Next-state, datapath update and registered-output decode.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        brw_d    = brw_q;
        cnt_d    = cnt_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        diff_d   = diff_q;
        bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // Capture operands now; later input changes cannot
                    // disturb the running operation.
                    a_sh_d   = bus.a;
                    b_sh_d   = bus.b;
                    brw_d    = bus.bin;
                    res_sh_d = {WIDTH{1'b0}};
                    cnt_d    = CNT_ZERO;
                    state_d  = ST_RUN;
                    busy_d   = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                end
            end

            ST_RUN: begin
                res_sh_d = res_next_s;
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                brw_d    = step_brw_s;
                if (cnt_q == CNT_LAST) begin
                    // Last bit: publish the complete result in one step.
                    state_d = ST_DONE;
                    cnt_d   = CNT_ZERO;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    diff_d  = res_next_s;
                    bout_d  = step_brw_s;
`ifdef SERIAL_SUB_OVF_EN
                    // At this point the operand LSBs are the original sign
                    // bits and step_diff_s is the result sign bit.
                    ovf_d   = (a_sh_q[0] != b_sh_q[0]) &&
                              (step_diff_s != a_sh_q[0]);
`endif
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = cnt_q + CNT_ONE;
                    busy_d  = 1'b1;
                end
            end

            ST_DONE: begin
                // start is ignored here; it is only sampled back in IDLE.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State and datapath register bank with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= {WIDTH{1'b0}};
            b_sh_q   <= {WIDTH{1'b0}};
            res_sh_q <= {WIDTH{1'b0}};
            brw_q    <= 1'b0;
            cnt_q    <= CNT_ZERO;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= {WIDTH{1'b0}};
            bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            brw_q    <= brw_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs come straight from registers
    // -------------------------------------------------------------------------
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule : serial_subtractor_8_bit

// File: tb/tb_serial_subtractor_8_bit.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor_8_bit
// Self-checking bench for serial_subtractor_8_bit. Expected results come
// from plain integer arithmetic on the operands.
// Optional macro SERIAL_SUB_OVF_EN enables the ovf checks.
// -----------------------------------------------------------------------------
module tb_serial_subtractor_8_bit;

    localparam int W = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [W-1:0] prev_diff;
    logic         prev_bout;
    logic         prev_ovf;

    serial_subtractor_8_bit_if #(.WIDTH(W)) bus ();

    serial_subtractor_8_bit #(.WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer subtraction
    function automatic logic [W-1:0] model_diff(input logic [W-1:0] ma,
                                                input logic [W-1:0] mb,
                                                input logic mbin);
        int d;
        d = int'(ma) - int'(mb) - int'(mbin);
        return W'((d + 1024) % 256);
    endfunction

    function automatic logic model_bout(input logic [W-1:0] ma,
                                        input logic [W-1:0] mb,
                                        input logic mbin);
        return int'(ma) < (int'(mb) + int'(mbin));
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] ma,
                                       input logic [W-1:0] mb,
                                       input logic mbin);
        logic [W-1:0] d;
        d = model_diff(ma, mb, mbin);
        return (ma[W-1] != mb[W-1]) && (d[W-1] != ma[W-1]);
    endfunction

    function automatic logic read_ovf();
`ifdef SERIAL_SUB_OVF_EN
        return bus.ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Drive one operation and observe it (no checking here)
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input logic obin, output int busy_cnt,
                         output logic seen, output logic [W-1:0] odiff,
                         output logic obout, output logic oovf,
                         output logic [W-1:0] mid_diff,
                         output logic done_after);
        int cyc;
        @(negedge clk);
        bus.start = 1'b1; bus.a = oa; bus.b = ob; bus.bin = obin;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
        mid_diff = bus.diff;
        busy_cnt = 0; seen = 1'b0; cyc = 0;
        while (!seen && cyc < 20) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (bus.busy) busy_cnt++;
                @(negedge clk);
                cyc++;
            end
        end
        odiff = bus.diff; obout = bus.bout; oovf = read_ovf();
        @(negedge clk);
        done_after = bus.done;
    endtask

    // Run one operation and compare everything against the model
    task automatic op_and_check(input logic [W-1:0] oa, input logic [W-1:0] ob,
                                input logic obin, input string tag);
        int bc; logic sn; logic [W-1:0] dd; logic bo; logic ov;
        logic [W-1:0] md; logic da;
        logic [W-1:0] ed; logic eb; logic eo;
        do_op(oa, ob, obin, bc, sn, dd, bo, ov, md, da);
        ed = model_diff(oa, ob, obin);
        eb = model_bout(oa, ob, obin);
        eo = model_ovf(oa, ob, obin);
        checks++;
        if (bc !== W) begin errors++; $display("FAIL %s busy_cycles got %0d want %0d", tag, bc, W); end
        checks++;
        if (sn !== 1'b1) begin errors++; $display("FAIL %s done_timeout got %b want 1", tag, sn); end
        checks++;
        if (md !== prev_diff) begin errors++; $display("FAIL %s diff_during_run got %0d want %0d", tag, md, prev_diff); end
        checks++;
        if (dd !== ed) begin errors++; $display("FAIL %s diff got %0d want %0d", tag, dd, ed); end
        checks++;
        if (bo !== eb) begin errors++; $display("FAIL %s bout got %b want %b", tag, bo, eb); end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ov !== eo) begin errors++; $display("FAIL %s ovf got %b want %b", tag, ov, eo); end
`endif
        checks++;
        if (da !== 1'b0) begin errors++; $display("FAIL %s done_width got %b want 0", tag, da); end
        prev_diff = ed; prev_bout = eb; prev_ovf = eo;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++;
        if (bus.diff !== 8'd0) begin errors++; $display("FAIL reset_diff got %0d want 0", bus.diff); end
        checks++;
        if (bus.bout !== 1'b0) begin errors++; $display("FAIL reset_bout got %b want 0", bus.bout); end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
`endif
        prev_diff = 8'd0; prev_bout = 1'b0; prev_ovf = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5] = '{8'd75, 8'd28, 8'd0,   8'd255, 8'd0};
        logic [W-1:0] tb [5] = '{8'd28, 8'd75, 8'd0,   8'd255, 8'd255};
        logic         tc [5] = '{1'b0,  1'b0,  1'b1,   1'b1,   1'b0};
        for (int i = 0; i < 5; i++) op_and_check(ta[i], tb[i], tc[i], "directed");
        checks++;
        if (prev_diff !== 8'd1) begin errors++; $display("FAIL directed_last_model got %0d want 1", prev_diff); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++)
            op_and_check(W'($urandom), W'($urandom), 1'($urandom), "random");
    endtask

    task automatic test_ignore_start();
        int dones; logic [W-1:0] dgot;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'd75; bus.b = 8'd28; bus.bin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.a = 8'd1; bus.b = 8'd1; bus.bin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0; dgot = 8'hxx;
        for (int c = 0; c < 25; c++) begin
            if (bus.done) begin dones++; dgot = bus.diff; end
            @(negedge clk);
        end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL ignore_start done_count got %0d want 1", dones); end
        checks++;
        if (dgot !== 8'd47) begin errors++; $display("FAIL ignore_start diff got %0d want 47", dgot); end
        prev_diff = 8'd47; prev_bout = 1'b0; prev_ovf = model_ovf(8'd75, 8'd28, 1'b0);
        op_and_check(8'd1, 8'd1, 1'b0, "after_ignore");
    endtask

    task automatic test_reset_mid_run();
        int dones;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'd200; bus.b = 8'd13; bus.bin = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
        checks++;
        if (bus.diff !== 8'd0) begin errors++; $display("FAIL midrst_diff got %0d want 0", bus.diff); end
        checks++;
        if (bus.bout !== 1'b0) begin errors++; $display("FAIL midrst_bout got %b want 0", bus.bout); end
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.done || bus.busy) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", dones); end
        prev_diff = 8'd0; prev_bout = 1'b0; prev_ovf = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cyc; logic sn; logic [W-1:0] d1; logic [W-1:0] d2; logic b2;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'd10; bus.b = 8'd3; bus.bin = 1'b0;
        @(negedge clk);
        bus.a = 8'd5; bus.b = 8'd9; bus.bin = 1'b1;
        sn = 1'b0; cyc = 0; d1 = 8'hxx;
        while (!sn && cyc < 20) begin
            if (bus.done) begin sn = 1'b1; d1 = bus.diff; end
            else begin @(negedge clk); cyc++; end
        end
        checks++;
        if (d1 !== 8'd7) begin errors++; $display("FAIL b2b_first_diff got %0d want 7", d1); end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got busy=%b done=%b want 0 0", bus.busy, bus.done); end
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_retrigger got busy=%b want 1", bus.busy); end
        sn = 1'b0; cyc = 0; d2 = 8'hxx; b2 = 1'bx;
        while (!sn && cyc < 20) begin
            if (bus.done) begin sn = 1'b1; d2 = bus.diff; b2 = bus.bout; end
            else begin @(negedge clk); cyc++; end
        end
        checks++;
        if (d2 !== model_diff(8'd5, 8'd9, 1'b1) || b2 !== 1'b1) begin
            errors++; $display("FAIL b2b_second got diff=%0d bout=%b want %0d 1", d2, b2, model_diff(8'd5, 8'd9, 1'b1));
        end
        @(negedge clk);
        prev_diff = model_diff(8'd5, 8'd9, 1'b1); prev_bout = 1'b1; prev_ovf = model_ovf(8'd5, 8'd9, 1'b1);
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf();
        int bc; logic sn; logic [W-1:0] dd; logic bo; logic ov; logic [W-1:0] md; logic da;
        do_op(8'd128, 8'd1, 1'b0, bc, sn, dd, bo, ov, md, da);
        checks++;
        if (dd !== 8'd127 || bo !== 1'b0 || ov !== 1'b1) begin
            errors++; $display("FAIL ovf_128_1 got diff=%0d bout=%b ovf=%b want 127 0 1", dd, bo, ov);
        end
        do_op(8'd100, 8'd50, 1'b0, bc, sn, dd, bo, ov, md, da);
        checks++;
        if (dd !== 8'd50 || bo !== 1'b0 || ov !== 1'b0) begin
            errors++; $display("FAIL ovf_100_50 got diff=%0d bout=%b ovf=%b want 50 0 0", dd, bo, ov);
        end
        prev_diff = 8'd50; prev_bout = 1'b0; prev_ovf = 1'b0;
    endtask
`endif

    initial begin
        checks = 0; errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_subtractor_8_bit
